// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

  // Controller FSM: normal issue, or holding the front end behind an MDU op in EX.
  typedef enum logic {
    RUN = 1'b0,
    MDU = 1'b1
  } state_t;

  // Register $zero never carries a real dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Default total EX residency of a multiply/divide op, in cycles.
  localparam int MDU_LATENCY_DEFAULT = 4;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side hazard inputs and controller-side sequencing outputs.
// The pipeline is the master (drives ID/EX fields); the controller is the slave.
interface hazard_stall_ctrl_if #(
  parameter int PERF_W = 16
);
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              id_branch_taken;
  logic              ex_mem_read;
  logic [4:0]        ex_rt;
  logic              ex_is_mdu;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_write;
  logic              idex_bubble;
  logic              exmem_bubble;
  logic              mdu_busy;
  logic              mdu_done;
  logic [PERF_W-1:0] stall_cycles;
  logic [PERF_W-1:0] flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_branch_taken,
           ex_mem_read, ex_rt, ex_is_mdu,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
           exmem_bubble, mdu_busy, mdu_done, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_branch_taken,
           ex_mem_read, ex_rt, ex_is_mdu,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
           exmem_bubble, mdu_busy, mdu_done, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// Combinational load-use hazard detector: the load in EX writes a register
// that the instruction in ID reads, so ID must wait one cycle for the data.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  output logic       hit
);

  logic rs_match;
  logic rt_match;

  assign rs_match = id_uses_rs && (id_rs == ex_rt);
  assign rt_match = id_uses_rt && (id_rt == ex_rt);
  assign hit      = ex_mem_read && (ex_rt != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central hazard/stall controller: MDU freeze FSM, load-use bubble, branch
// flush, and saturating stall/flush performance counters.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MDU_LATENCY = MDU_LATENCY_DEFAULT,
  parameter int CNT_W       = 4,
  parameter int PERF_W      = 16
) (
  input logic           clk,
  input logic           rst,
  hazard_stall_ctrl_if.slave bus
);

  // Residency counter value on entry: the entry cycle and the exit cycle are
  // not counted, leaving MDU_LATENCY-2 further stall cycles in the MDU state.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MDU_LATENCY - 2);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              mdu_stall;
  logic              mdu_exit;
  logic              load_use_hit;
  logic [PERF_W-1:0] stall_cycles;
  logic [PERF_W-1:0] flush_count;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  load_use_detect u_load_use_detect (
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .id_uses_rs  (bus.id_uses_rs),
    .id_uses_rt  (bus.id_uses_rt),
    .ex_mem_read (bus.ex_mem_read),
    .ex_rt       (bus.ex_rt),
    .hit         (load_use_hit)
  );

  // State and residency counter; reset aborts any MDU op in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // FSM next state: enter on an MDU op in EX, count down, exit with done.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mdu_stall = 1'b0;
    mdu_exit  = 1'b0;
    case (state)
      RUN: begin
        if (bus.ex_is_mdu) begin
          mdu_stall = 1'b1;
          state_nxt = MDU;
          cnt_nxt   = CNT_INIT;
        end
      end
      MDU: begin
        if (cnt != '0) begin
          mdu_stall = 1'b1;
          cnt_nxt   = cnt - 1'b1;
        end else begin
          mdu_exit  = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Priority output decode: MDU stall, then load-use, then branch flush.
  always_comb begin
    bus.pc_write     = 1'b1;
    bus.ifid_write   = 1'b1;
    bus.ifid_flush   = 1'b0;
    bus.idex_write   = 1'b1;
    bus.idex_bubble  = 1'b0;
    bus.exmem_bubble = 1'b0;
    bus.mdu_busy     = (state == MDU);
    bus.mdu_done     = mdu_exit;
    if (rst) begin
      bus.pc_write   = 1'b0;
      bus.ifid_write = 1'b0;
      bus.idex_write = 1'b0;
      bus.mdu_busy   = 1'b0;
      bus.mdu_done   = 1'b0;
    end else if (mdu_stall) begin
      bus.pc_write     = 1'b0;
      bus.ifid_write   = 1'b0;
      bus.idex_write   = 1'b0;
      bus.exmem_bubble = 1'b1;
    end else if (load_use_hit) begin
      bus.pc_write    = 1'b0;
      bus.ifid_write  = 1'b0;
      bus.idex_bubble = 1'b1;
    end else if (bus.id_branch_taken) begin
      bus.ifid_flush = 1'b1;
    end
  end

  // Saturating performance counters for front-end stall and flush cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!bus.pc_write)  stall_cycles <= sat_inc(stall_cycles);
      if (bus.ifid_flush) flush_count  <= sat_inc(flush_count);
    end
  end

  assign bus.stall_cycles = stall_cycles;
  assign bus.flush_count  = flush_count;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (latency 4 / 16-bit counters and
// latency 2 / 4-bit counters) share one input stream and are compared each
// cycle against a cycle-position reference model.
module tb_hazard_stall_ctrl;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rs, id_uses_rt, id_branch_taken, ex_mem_read, ex_is_mdu;

  hazard_stall_ctrl_if #(.PERF_W(16)) bus_a ();
  hazard_stall_ctrl_if #(.PERF_W(4))  bus_b ();

  assign bus_a.id_rs = id_rs;             assign bus_b.id_rs = id_rs;
  assign bus_a.id_rt = id_rt;             assign bus_b.id_rt = id_rt;
  assign bus_a.id_uses_rs = id_uses_rs;   assign bus_b.id_uses_rs = id_uses_rs;
  assign bus_a.id_uses_rt = id_uses_rt;   assign bus_b.id_uses_rt = id_uses_rt;
  assign bus_a.id_branch_taken = id_branch_taken;
  assign bus_b.id_branch_taken = id_branch_taken;
  assign bus_a.ex_mem_read = ex_mem_read; assign bus_b.ex_mem_read = ex_mem_read;
  assign bus_a.ex_rt = ex_rt;             assign bus_b.ex_rt = ex_rt;
  assign bus_a.ex_is_mdu = ex_is_mdu;     assign bus_b.ex_is_mdu = ex_is_mdu;

  hazard_stall_ctrl #(.MDU_LATENCY(4), .CNT_W(4), .PERF_W(16)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a.slave));
  hazard_stall_ctrl #(.MDU_LATENCY(2), .CNT_W(4), .PERF_W(4)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b.slave));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pos = op cycles already spent in EX by the current MDU op
  // (0 = none). Counters are plain integers clamped at the counter maximum.
  int pos[2];
  int sc[2];
  int fc[2];
  int lat[2]  = '{4, 2};
  int maxc[2] = '{65535, 15};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int op_cycle(input int d);
    if (pos[d] > 0) return pos[d] + 1;
    return ex_is_mdu ? 1 : 0;
  endfunction

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble, mdu_busy, mdu_done}
  function automatic logic [7:0] model_out(input int d);
    int k;
    logic stall, ld, done;
    k     = op_cycle(d);
    stall = (k >= 1) && (k <= lat[d] - 1);
    done  = (k == lat[d]);
    ld    = ex_mem_read && (ex_rt != 5'd0) &&
            ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
    return {!(stall || ld), !(stall || ld), !stall && !ld && id_branch_taken,
            !stall, !stall && ld, stall, pos[d] > 0, done};
  endfunction

  function automatic logic [7:0] obs_a();
    return {bus_a.pc_write, bus_a.ifid_write, bus_a.ifid_flush, bus_a.idex_write,
            bus_a.idex_bubble, bus_a.exmem_bubble, bus_a.mdu_busy, bus_a.mdu_done};
  endfunction

  function automatic logic [7:0] obs_b();
    return {bus_b.pc_write, bus_b.ifid_write, bus_b.ifid_flush, bus_b.idex_write,
            bus_b.idex_bubble, bus_b.exmem_bubble, bus_b.mdu_busy, bus_b.mdu_done};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      pos[d] = 0; sc[d] = 0; fc[d] = 0;
    end
  endtask

  task automatic quiet();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_branch_taken = 1'b0;
    ex_mem_read = 1'b0; ex_is_mdu = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] r);
    ex_mem_read = 1'b1; ex_rt = r; id_uses_rs = 1'b1; id_rs = r;
  endtask

  // One clock: compare mid-cycle, then advance the model across the edge.
  task automatic step(input string tag);
    logic [7:0] ea, eb;
    int k;
    @(negedge clk);
    ea = model_out(0);
    eb = model_out(1);
    chk({tag, "_a_outs"}, 32'(obs_a()), 32'(ea));
    chk({tag, "_b_outs"}, 32'(obs_b()), 32'(eb));
    chk({tag, "_a_stall"}, 32'(bus_a.stall_cycles), 32'(sc[0]));
    chk({tag, "_b_stall"}, 32'(bus_b.stall_cycles), 32'(sc[1]));
    chk({tag, "_a_flush"}, 32'(bus_a.flush_count), 32'(fc[0]));
    chk({tag, "_b_flush"}, 32'(bus_b.flush_count), 32'(fc[1]));
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      logic [7:0] e;
      e = (d == 0) ? ea : eb;
      if (!e[7] && sc[d] < maxc[d]) sc[d]++;
      if (e[5] && fc[d] < maxc[d]) fc[d]++;
      k = op_cycle(d);
      pos[d] = (k == 0 || k == lat[d]) ? 0 : k;
    end
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_a_outs"}, 32'(obs_a()), 32'd0);
    chk({tag, "_b_outs"}, 32'(obs_b()), 32'd0);
    chk({tag, "_a_stall"}, 32'(bus_a.stall_cycles), 32'd0);
    chk({tag, "_b_flush"}, 32'(bus_b.flush_count), 32'd0);
  endtask

  initial begin
    quiet();
    model_reset();
    ex_is_mdu = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_reset_outs("rst_init");
    quiet();
    rst = 1'b0;
    model_reset();

    step("idle0");
    step("idle1");

    // Load-use on rs: exactly one bubble, then $zero destination never stalls.
    load_use(5'd8);
    step("lu_hit");
    chk("lu_stall_count", 32'(bus_a.stall_cycles), 32'd1);
    quiet();
    step("lu_after");
    load_use(5'd0);
    step("lu_zero");
    quiet();
    ex_mem_read = 1'b1; ex_rt = 5'd9; id_uses_rt = 1'b1; id_rt = 5'd9;
    step("lu_rt");
    quiet();

    // Branch flush alone, then suppressed by a coincident load-use.
    id_branch_taken = 1'b1;
    step("br_flush");
    load_use(5'd3);
    step("br_lu");
    quiet();
    step("br_quiet");

    // Two back-to-back MDU ops with ex_is_mdu held throughout.
    ex_is_mdu = 1'b1;
    begin
      int s0;
      s0 = sc[0];
      for (int i = 0; i < 4; i++) step("mdu1");
      chk("mdu_stall_count", 32'(bus_a.stall_cycles), 32'(s0 + 3));
    end
    for (int i = 0; i < 4; i++) step("mdu2");
    quiet();
    step("mdu_idle");

    // MDU stall outranks a load-use hit and a taken branch.
    ex_is_mdu = 1'b1; load_use(5'd5); id_branch_taken = 1'b1;
    step("mdu_over_lu");
    quiet();
    for (int i = 0; i < 4; i++) step("mdu_drain");

    // Reset in the middle of an MDU op aborts it without a done pulse.
    ex_is_mdu = 1'b1;
    step("abort0");
    step("abort1");
    rst = 1'b1;
    #1;
    check_reset_outs("rst_mid");
    @(posedge clk);
    #1;
    check_reset_outs("rst_hold");
    rst = 1'b0;
    model_reset();
    quiet();
    step("post_rst");

    // Hold a load-use stall long enough to saturate the 4-bit counter.
    load_use(5'd12);
    for (int i = 0; i < 20; i++) step("sat");
    chk("sat_b_stall", 32'(bus_b.stall_cycles), 32'd15);
    quiet();

    // Randomised traffic with small register numbers to provoke matches.
    for (int i = 0; i < 400; i++) begin
      id_rs           = 5'($urandom_range(3));
      id_rt           = 5'($urandom_range(3));
      ex_rt           = 5'($urandom_range(3));
      id_uses_rs      = 1'($urandom_range(1));
      id_uses_rt      = 1'($urandom_range(1));
      ex_mem_read     = 1'($urandom_range(1));
      id_branch_taken = ($urandom_range(3) == 0);
      ex_is_mdu       = ($urandom_range(5) == 0);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
